// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the main-memory arbiter: FSM state encoding,
//   transaction owner encoding and the block-offset mask helper.
//   No ports.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StWrite = 2'd2
   } state_e;

   typedef enum logic {
      OwnI = 1'b0,
      OwnD = 1'b1
   } owner_e;

   localparam int unsigned BytesPerWord = 2;

   // Byte-offset mask of one cache block; base = addr & ~offsetMask(blockWords).
   function automatic int unsigned offsetMask(input int unsigned blockWords);
      return BytesPerWord * blockWords - 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// mem_arbiter_rr2
//   Two-requester round-robin picker. A lone requester always wins; on a
//   tie the side that did not own the previous transaction wins.
// Ports
//   req        in   2  request vector, bit 0 = I side, bit 1 = D side
//   lastOwner  in   1  owner of the most recently completed transaction
//   gnt        out  2  one-hot (or zero) grant, same bit order as req
module mem_arbiter_rr2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  owner_e     lastOwner,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (lastOwner == OwnI) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single pipelined main memory between the I-cache and the
//   D-cache. One transaction at a time: a block fill (BLOCK_WORDS reads,
//   data forwarded to the owner as it returns) or a single-word D write.
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   i_req, i_addr                 I-side fill request (level) and miss address
//   i_grant, i_done               1-cycle pulses: I transaction start / end
//   i_rvalid, i_widx, i_rdata     I-side fill word and its index in the block
//   d_req, d_wr, d_addr, d_wdata  D-side request: d_wr=1 write, 0 fill
//   d_grant, d_done, d_rvalid,
//   d_widx, d_rdata               as I side
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                     memory command (word-aligned byte address)
//   mem_rvalid, mem_rdata         memory read return, fixed latency, in order
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_req,
   input  logic [ADDR_W-1:0]              i_addr,
   output logic                           i_grant,
   output logic                           i_rvalid,
   output logic [$clog2(BLOCK_WORDS)-1:0] i_widx,
   output logic [DATA_W-1:0]              i_rdata,
   output logic                           i_done,
   input  logic                           d_req,
   input  logic                           d_wr,
   input  logic [ADDR_W-1:0]              d_addr,
   input  logic [DATA_W-1:0]              d_wdata,
   output logic                           d_grant,
   output logic                           d_rvalid,
   output logic [$clog2(BLOCK_WORDS)-1:0] d_widx,
   output logic [DATA_W-1:0]              d_rdata,
   output logic                           d_done,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic                           mem_rvalid,
   input  logic [DATA_W-1:0]              mem_rdata
);

   localparam int unsigned IdxW = $clog2(BLOCK_WORDS);
   localparam int unsigned CntW = IdxW + 1;

   localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'(offsetMask(BLOCK_WORDS));
   localparam logic [CntW-1:0]   BlockCnt = CntW'(BLOCK_WORDS);
   localparam logic [CntW-1:0]   LastCnt  = CntW'(BLOCK_WORDS - 1);

   state_e             stateQ, stateD;
   owner_e             ownerQ, ownerD;
   owner_e             lastOwnerQ, lastOwnerD;
   logic [ADDR_W-1:0]  baseQ, baseD;
   logic [ADDR_W-1:0]  wrAddrQ, wrAddrD;
   logic [DATA_W-1:0]  wrDataQ, wrDataD;
   logic [CntW-1:0]    issueQ, issueD;
   logic [CntW-1:0]    retQ, retD;

   logic [1:0]         gnt;
   logic               issuing;
   logic               fwd;
   logic               lastRet;

   mem_arbiter_rr2 uRr (
      .req       ({d_req, i_req}),
      .lastOwner (lastOwnerQ),
      .gnt       (gnt)
   );

   // Returns are only accepted while a fill is in flight and not yet complete;
   // anything else on mem_rvalid is a stray and is dropped.
   assign issuing = (stateQ == StFill) && (issueQ < BlockCnt);
   assign fwd     = (stateQ == StFill) && mem_rvalid && (retQ < BlockCnt);
   assign lastRet = fwd && (retQ == LastCnt);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         stateQ     <= StIdle;
         ownerQ     <= OwnI;
         lastOwnerQ <= OwnI;
         baseQ      <= '0;
         wrAddrQ    <= '0;
         wrDataQ    <= '0;
         issueQ     <= '0;
         retQ       <= '0;
      end else begin
         stateQ     <= stateD;
         ownerQ     <= ownerD;
         lastOwnerQ <= lastOwnerD;
         baseQ      <= baseD;
         wrAddrQ    <= wrAddrD;
         wrDataQ    <= wrDataD;
         issueQ     <= issueD;
         retQ       <= retD;
      end
   end

   // Next-state and latch updates
   always_comb begin
      stateD     = stateQ;
      ownerD     = ownerQ;
      lastOwnerD = lastOwnerQ;
      baseD      = baseQ;
      wrAddrD    = wrAddrQ;
      wrDataD    = wrDataQ;
      issueD     = issueQ;
      retD       = retQ;
      case (stateQ)
         StIdle: begin
            if (gnt != 2'b00) begin
               issueD = '0;
               retD   = '0;
               if (gnt[1]) begin
                  ownerD  = OwnD;
                  baseD   = d_addr & ~OffMask;
                  wrAddrD = d_addr & ~ADDR_W'(1);
                  wrDataD = d_wdata;
                  stateD  = d_wr ? StWrite : StFill;
               end else begin
                  ownerD = OwnI;
                  baseD  = i_addr & ~OffMask;
                  stateD = StFill;
               end
            end
         end
         StFill: begin
            if (issuing) issueD = issueQ + 1'b1;
            if (fwd)     retD   = retQ + 1'b1;
            if (lastRet) begin
               stateD     = StIdle;
               lastOwnerD = ownerQ;
            end
         end
         StWrite: begin
            stateD     = StIdle;
            lastOwnerD = OwnD;
         end
         default: stateD = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      i_grant   = 1'b0;
      i_rvalid  = 1'b0;
      i_widx    = '0;
      i_rdata   = '0;
      i_done    = 1'b0;
      d_grant   = 1'b0;
      d_rvalid  = 1'b0;
      d_widx    = '0;
      d_rdata   = '0;
      d_done    = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (stateQ)
         StFill: begin
            if (issuing) begin
               mem_en   = 1'b1;
               // Word k of the block sits at byte offset 2*k.
               mem_addr = baseQ + ADDR_W'({issueQ, 1'b0});
            end
            if (ownerQ == OwnI) begin
               i_grant  = (issueQ == '0);
               i_rvalid = fwd;
               i_done   = lastRet;
               if (fwd) begin
                  i_widx  = retQ[IdxW-1:0];
                  i_rdata = mem_rdata;
               end
            end else begin
               d_grant  = (issueQ == '0);
               d_rvalid = fwd;
               d_done   = lastRet;
               if (fwd) begin
                  d_widx  = retQ[IdxW-1:0];
                  d_rdata = mem_rdata;
               end
            end
         end
         StWrite: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = wrAddrQ;
            mem_wdata = wrDataQ;
            d_grant   = 1'b1;
            d_done    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a fixed-latency (4) memory model.
//   A table of single transactions is applied in a loop; hand-written
//   sequences cover the reset tie, alternation, reset mid-fill and stray
//   returns.
module tb_mem_arbiter;

   localparam int unsigned Lat = 4;
   localparam int unsigned BW  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic        i_grant, i_rvalid, i_done;
   logic [2:0]  i_widx;
   logic [15:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_grant, d_rvalid, d_done;
   logic [2:0]  d_widx;
   logic [15:0] d_rdata;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;

   logic        spur = 1'b0;
   logic [Lat-1:0] pv;
   logic [15:0] pa [Lat];

   int nVec = 0;
   int nBad = 0;

   mem_arbiter #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .BLOCK_WORDS (BW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_grant    (i_grant),
      .i_rvalid   (i_rvalid),
      .i_widx     (i_widx),
      .i_rdata    (i_rdata),
      .i_done     (i_done),
      .d_req      (d_req),
      .d_wr       (d_wr),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_grant    (d_grant),
      .d_rvalid   (d_rvalid),
      .d_widx     (d_widx),
      .d_rdata    (d_rdata),
      .d_done     (d_done),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory: read issued in cycle c returns in cycle c+Lat with data addr^5A5A.
   always @(posedge clk) begin
      if (!rst) begin
         pv <= '0;
      end else begin
         pv    <= {pv[Lat-2:0], mem_en && !mem_wr};
         pa[0] <= mem_addr;
         for (int i = 1; i < Lat; i++) pa[i] <= pa[i-1];
      end
   end

   assign mem_rvalid = pv[Lat-1] | spur;
   assign mem_rdata  = pv[Lat-1] ? (pa[Lat-1] ^ 16'h5A5A) : 16'hDEAD;

   typedef struct {
      logic        iReq;
      logic [15:0] iAddr;
      logic        dReq;
      logic        dWr;
      logic [15:0] dAddr;
      logic [15:0] dWdata;
      logic        expD;
      logic        expWr;
      logic [15:0] expAddr;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic checkIdle(input string nm);
      chk({nm, " ctl"}, 32'({mem_en, mem_wr, i_grant, i_rvalid, i_done,
                             d_grant, d_rvalid, d_done}), 32'd0);
      chk({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
   endtask

   task automatic checkAllZero(input string nm);
      checkIdle(nm);
      chk({nm, " mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({nm, " widx"}, 32'({i_widx, d_widx}), 32'd0);
      chk({nm, " rdata"}, {i_rdata, d_rdata}, 32'd0);
   endtask

   task automatic checkWrite(input logic [15:0] addr, input logic [15:0] data);
      chk("wr en/wr", 32'({mem_en, mem_wr}), 32'd3);
      chk("wr mem_addr", 32'(mem_addr), 32'(addr));
      chk("wr mem_wdata", 32'(mem_wdata), 32'(data));
      chk("wr d_grant/d_done", 32'({d_grant, d_done}), 32'd3);
      chk("wr i side quiet", 32'({i_grant, i_rvalid, i_done, d_rvalid}), 32'd0);
   endtask

   // Called in the grant cycle; returns in the owner's done cycle.
   task automatic runFill(input logic side, input logic [15:0] base);
      int  iss = 0;
      int  ret = 0;
      int  cyc = 0;
      bit  fin = 1'b0;
      logic ownGnt, ownRv, ownDone, othQuiet;
      logic [2:0]  ownIdx;
      logic [15:0] ownData;
      while (!fin && cyc < 40) begin
         ownGnt   = side ? d_grant  : i_grant;
         ownRv    = side ? d_rvalid : i_rvalid;
         ownDone  = side ? d_done   : i_done;
         ownIdx   = side ? d_widx   : i_widx;
         ownData  = side ? d_rdata  : i_rdata;
         othQuiet = side ? !(i_grant | i_rvalid | i_done) : !(d_grant | d_rvalid | d_done);
         chk("fill grant pulse", 32'(ownGnt), (cyc == 0) ? 32'd1 : 32'd0);
         chk("fill non-owner quiet", 32'(othQuiet), 32'd1);
         if (mem_en) begin
            chk("fill mem_wr", 32'(mem_wr), 32'd0);
            chk("fill mem_addr", 32'(mem_addr), 32'(base + 16'(2 * iss)));
            iss++;
         end
         if (ownRv) begin
            chk("fill widx", 32'(ownIdx), 32'(ret % BW));
            chk("fill rdata", 32'(ownData), 32'((base + 16'(2 * ret)) ^ 16'h5A5A));
            ret++;
         end
         if (ownDone) begin
            chk("done with last word", 32'({ownRv, 8'(ret)}), 32'({1'b1, 8'(BW)}));
            chk("done cycle", 32'(cyc), 32'(BW + Lat - 1));
            fin = 1'b1;
         end else begin
            tick();
            cyc++;
         end
      end
      if (!fin) chk("fill done timeout", 32'd0, 32'd1);
      chk("fill issue count", 32'(iss), 32'(BW));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 16'h0036, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0030};
      vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1235, 16'h0000, 1'b1, 1'b0, 16'h1230};
      vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1235, 16'hBEEF, 1'b1, 1'b1, 16'h1234};
      vecs[3] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFF0};
      vecs[4] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h2001, 16'h0000, 1'b1, 1'b0, 16'h2000};
      vecs[5] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h4444, 16'h0000, 1'b0, 1'b0, 16'h0100};
      vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'hA5A5, 1'b1, 1'b1, 16'h0000};

      // Reset state
      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b1;
      tick();
      checkAllZero("idle after reset");

      // First tie after reset goes to D; both held high -> alternation.
      i_req = 1'b1; i_addr = 16'h0200;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
      tick();
      runFill(1'b1, 16'h0300);
      tick();
      checkIdle("idle after d_done");
      tick();
      runFill(1'b0, 16'h0200);
      tick();
      checkIdle("idle after i_done");
      tick();
      runFill(1'b1, 16'h0300);
      i_req = 1'b0; d_req = 1'b0;
      tick();
      checkIdle("idle after alternation");

      // Transaction table; requests drop right after the grant edge.
      for (int v = 0; v < 7; v++) begin
         i_req = vecs[v].iReq;  i_addr  = vecs[v].iAddr;
         d_req = vecs[v].dReq;  d_wr    = vecs[v].dWr;
         d_addr = vecs[v].dAddr; d_wdata = vecs[v].dWdata;
         tick();
         i_req = 1'b0; d_req = 1'b0;
         if (vecs[v].expWr) checkWrite(vecs[v].expAddr, vecs[v].dWdata);
         else runFill(vecs[v].expD, vecs[v].expAddr);
         tick();
         checkAllZero("idle after vector");
      end

      // Reset during the 4th issue of a fill.
      i_req = 1'b1; i_addr = 16'h0040;
      tick();
      i_req = 1'b0;
      tick();
      tick();
      tick();
      chk("4th issue addr", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h0046}));
      rst = 1'b0;
      tick();
      checkAllZero("after mid-fill reset");
      rst = 1'b1;
      spur = 1'b1;
      #1;
      chk("stray rvalid after reset", 32'({i_rvalid, i_done, d_rvalid, d_done}), 32'd0);
      tick();
      spur = 1'b0;
      i_req = 1'b1; i_addr = 16'h0080;
      tick();
      i_req = 1'b0;
      runFill(1'b0, 16'h0080);

      // Stray returns in IDLE: nothing forwarded, no extra done, counters intact.
      spur = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("spurious idle", 32'({i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done}),
             32'd0);
      end
      spur = 1'b0;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h7778;
      tick();
      d_req = 1'b0;
      runFill(1'b1, 16'h7770);
      tick();
      checkAllZero("final idle");

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
